data_memory_sized: RTL and testbench

- Parametrised successor to the core's word-only data memory.
- Byte-addressed RISC-V load/store memory: byte/half/word stores via per-byte lane enables; signed/unsigned loads with sign/zero extension.
- Adds misalignment detection, a configurable read latency with a valid strobe, and an optional zero-clear sequence after reset.
- Sits between the MEM-stage ALU address/store data and the writeback mux.

---
 rtl/data_memory_sized_if.sv | 27 ++
 rtl/data_memory_sized.sv | 191 +++++++++++++++++++
 tb/tb_data_memory_sized.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_sized_if.sv
// data_memory_sized_if: MEM-stage load/store bus
// master = pipeline side, slave = memory side
interface data_memory_sized_if;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [2:0]  size;
  logic        ready;
  logic [31:0] read_data;
  logic        rd_valid;
  logic        misaligned;

  modport master (
    output addr, write_data, memwrite,
    output memread, size,
    input  ready, read_data, rd_valid,
    input  misaligned
  );

  modport slave (
    input  addr, write_data, memwrite,
    input  memread, size,
    output ready, read_data, rd_valid,
    output misaligned
  );
endinterface

// File: rtl/data_memory_sized.sv
// data_memory_sized: byte-addressed RISC-V data memory
// sized loads/stores, misalign flag, 1/2-cycle reads, clear-on-reset
module data_memory_sized #(
  parameter int DEPTH_WORDS    = 2048,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  data_memory_sized_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST = AW'(DEPTH_WORDS - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ready, clr_we;

  // state register and clear counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // sweep one word per cycle, then run
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    clr_we  = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        if (CLEAR_ON_RESET) begin
          clr_we = !rst;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST)
            state_d = S_RUN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: ready = 1'b1;
    endcase
  end

  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          is_b, is_h, is_w;
  logic          mis, acc, rd_acc, we;
  logic [3:0]    be;
  logic [31:0]   wdat;
  logic          unused_addr;

  assign idx  = bus.addr[AW+1:2];
  assign off  = bus.addr[1:0];
  assign unused_addr = ^bus.addr[31:AW+2];

  assign is_b = bus.size == 3'b000 ||
                bus.size == 3'b100;
  assign is_h = bus.size == 3'b001 ||
                bus.size == 3'b101;
  assign is_w = bus.size == 3'b010;

  // illegal sizes count as misaligned
  assign mis = !(is_b || is_h || is_w) ||
               (is_h && off[0]) ||
               (is_w && off != 2'b00);

  assign acc = ready && !rst &&
               (bus.memread || bus.memwrite);
  assign rd_acc = acc && bus.memread;
  assign we     = acc && bus.memwrite && !mis;

  // lane enables and lane-replicated store data
  always_comb begin
    be   = 4'b0000;
    wdat = bus.write_data;
    unique case (1'b1)
      is_b: begin
        be   = 4'b0001 << off;
        wdat = {4{bus.write_data[7:0]}};
      end
      is_h: begin
        be   = off[1] ? 4'b1100 : 4'b0011;
        wdat = {2{bus.write_data[15:0]}};
      end
      is_w:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  logic [31:0] mem_q [DEPTH_WORDS];

  // clear sweep or byte-lane store
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[cnt_q] <= '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b])
          mem_q[idx][8*b +: 8] <= wdat[8*b +: 8];
    end
  end

  logic        s1_v_q, s1_mis_q, st_mis_q;
  logic [31:0] word_q;
  logic [1:0]  s1_off_q;
  logic [2:0]  s1_sz_q;

  // read stage 1: old word plus select info
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_mis_q <= 1'b0;
      st_mis_q <= 1'b0;
      word_q   <= '0;
      s1_off_q <= '0;
      s1_sz_q  <= '0;
    end else begin
      s1_v_q   <= rd_acc;
      st_mis_q <= acc && bus.memwrite &&
                  !bus.memread && mis;
      if (rd_acc) begin
        word_q   <= mem_q[idx];
        s1_mis_q <= mis;
        s1_off_q <= off;
        s1_sz_q  <= bus.size;
      end
    end
  end

  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ld;

  // lane select and sign/zero extension
  always_comb begin
    lb = word_q[8*s1_off_q +: 8];
    lh = s1_off_q[1] ? word_q[31:16]
                     : word_q[15:0];
    unique case (s1_sz_q)
      3'b000:  ld = {{24{lb[7]}}, lb};
      3'b001:  ld = {{16{lh[15]}}, lh};
      3'b010:  ld = word_q;
      3'b100:  ld = {24'h0, lb};
      3'b101:  ld = {16'h0, lh};
      default: ld = '0;
    endcase
    if (s1_mis_q)
      ld = '0;
  end

  assign bus.ready = ready;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic        v_q, m_q;
      logic [31:0] d_q;

      // extra output register stage
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
          m_q <= 1'b0;
          d_q <= '0;
        end else begin
          v_q <= s1_v_q;
          m_q <= s1_v_q && s1_mis_q;
          if (s1_v_q)
            d_q <= ld;
        end
      end

      assign bus.rd_valid   = v_q;
      assign bus.read_data  = d_q;
      assign bus.misaligned = m_q || st_mis_q;
    end else begin : g_lat1
      assign bus.rd_valid   = s1_v_q;
      assign bus.read_data  = ld;
      assign bus.misaligned = (s1_v_q && s1_mis_q) ||
                              st_mis_q;
    end
  endgenerate
endmodule

// File: tb/tb_data_memory_sized.sv
// tb_data_memory_sized: directed bench, latency 1 and 2
// both instances share stimulus, 16 words, clear on reset
module tb_data_memory_sized;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic        mw = 1'b0;
  logic        mr = 1'b0;
  logic [2:0]  sz = 3'b010;
  int          tests = 0;
  int          fails = 0;

  logic [31:0] o_d1, o_d2;
  logic        o_v1, o_m1, o_v2e, o_m2e, o_v2, o_m2;

  data_memory_sized_if b1 ();
  data_memory_sized_if b2 ();

  assign b1.addr       = addr;
  assign b1.write_data = wd;
  assign b1.memwrite   = mw;
  assign b1.memread    = mr;
  assign b1.size       = sz;
  assign b2.addr       = addr;
  assign b2.write_data = wd;
  assign b2.memwrite   = mw;
  assign b2.memread    = mr;
  assign b2.size       = sz;

  data_memory_sized #(
    .DEPTH_WORDS(16), .READ_LATENCY(1),
    .CLEAR_ON_RESET(1'b1)
  ) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  data_memory_sized #(
    .DEPTH_WORDS(16), .READ_LATENCY(2),
    .CLEAR_ON_RESET(1'b1)
  ) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(
    input  logic [31:0] a, d,
    input  logic        w, r,
    input  logic [2:0]  s,
    output logic [31:0] d1,
    output logic        v1, m1, v2e, m2e,
    output logic [31:0] d2,
    output logic        v2, m2
  );
    addr = a; wd = d; mw = w; mr = r; sz = s;
    step();
    mw = 1'b0; mr = 1'b0;
    d1 = b1.read_data; v1 = b1.rd_valid;
    m1 = b1.misaligned;
    v2e = b2.rd_valid; m2e = b2.misaligned;
    step();
    d2 = b2.read_data; v2 = b2.rd_valid;
    m2 = b2.misaligned;
  endtask

  task automatic test_reset();
    int lows, vseen;
    rst = 1'b1; mr = 1'b1; addr = '0; sz = 3'b010;
    repeat (3) step();
    tests++;
    if ({b1.ready, b1.rd_valid, b1.misaligned,
         b1.read_data, b2.ready, b2.rd_valid,
         b2.misaligned, b2.read_data} !== 70'h0) begin
      fails++;
      $display("FAIL reset_values: rdy=%b/%b v=%b/%b m=%b/%b d=%h/%h want all 0",
        b1.ready, b2.ready, b1.rd_valid, b2.rd_valid,
        b1.misaligned, b2.misaligned,
        b1.read_data, b2.read_data);
    end
    rst = 1'b0;
    lows = 0; vseen = 0;
    for (int i = 0; i < 16; i++) begin
      if (!b1.ready && !b2.ready) lows++;
      if (b1.rd_valid || b2.rd_valid) vseen++;
      step();
    end
    tests++;
    if (lows !== 16) begin
      fails++;
      $display("FAIL clear_ready_low: got %0d cycles want 16", lows);
    end
    tests++;
    if (vseen !== 0) begin
      fails++;
      $display("FAIL clear_no_rdvalid: got %0d pulses want 0", vseen);
    end
    tests++;
    if ({b1.ready, b2.ready} !== 2'b11) begin
      fails++;
      $display("FAIL ready_after_clear: got %b%b want 11",
        b1.ready, b2.ready);
    end
    mr = 1'b0;
    xfer(32'h0, 32'h0, 1'b0, 1'b1, 3'b010, o_d1,
         o_v1, o_m1, o_v2e, o_m2e, o_d2, o_v2, o_m2);
    tests++;
    if ({o_v1, o_d1, o_v2e, o_v2, o_d2} !==
        {1'b1, 32'h0, 1'b0, 1'b1, 32'h0}) begin
      fails++;
      $display("FAIL lw_0_after_clear: v1=%b d1=%h v2e=%b v2=%b d2=%h want d=00000000",
        o_v1, o_d1, o_v2e, o_v2, o_d2);
    end
  endtask

  task automatic test_sized_loads();
    logic [31:0] la [4] = '{32'h11, 32'h13,
                            32'h12, 32'h10};
    logic [2:0]  ls [4] = '{3'b000, 3'b100,
                            3'b001, 3'b101};
    logic [31:0] le [4] = '{32'hFFFFFFBE, 32'h000000DE,
                            32'hFFFFDEAD, 32'h0000BEEF};
    xfer(32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 3'b010,
         o_d1, o_v1, o_m1, o_v2e, o_m2e,
         o_d2, o_v2, o_m2);
    tests++;
    if ({o_v1, o_m1, o_v2e, o_m2e, o_v2, o_m2}
        !== 6'b0) begin
      fails++;
      $display("FAIL sw_0x10_flags: v1=%b m1=%b v2e=%b m2e=%b v2=%b m2=%b want 0",
        o_v1, o_m1, o_v2e, o_m2e, o_v2, o_m2);
    end
    for (int i = 0; i < 4; i++) begin
      xfer(la[i], 32'h0, 1'b0, 1'b1, ls[i],
           o_d1, o_v1, o_m1, o_v2e, o_m2e,
           o_d2, o_v2, o_m2);
      tests++;
      if ({o_v1, o_m1, o_d1, o_v2e, o_v2, o_m2, o_d2}
          !== {2'b10, le[i], 3'b010, le[i]}) begin
        fails++;
        $display("FAIL sized_load a=%h sz=%b: v1=%b m1=%b d1=%h v2e=%b v2=%b m2=%b d2=%h want %h",
          la[i], ls[i], o_v1, o_m1, o_d1, o_v2e,
          o_v2, o_m2, o_d2, le[i]);
      end
    end
  endtask

  task automatic test_partial_stores();
    xfer(32'h12, 32'h55, 1'b1, 1'b0, 3'b000,
         o_d1, o_v1, o_m1, o_v2e, o_m2e,
         o_d2, o_v2, o_m2);
    xfer(32'h10, 32'h0, 1'b0, 1'b1, 3'b010,
         o_d1, o_v1, o_m1, o_v2e, o_m2e,
         o_d2, o_v2, o_m2);
    tests++;
    if ({o_v1, o_d1, o_v2, o_d2} !==
        {1'b1, 32'hDE55BEEF, 1'b1, 32'hDE55BEEF}) begin
      fails++;
      $display("FAIL sb_then_lw: v1=%b d1=%h v2=%b d2=%h want DE55BEEF",
        o_v1, o_d1, o_v2, o_d2);
    end
    xfer(32'h10, 32'h1234, 1'b1, 1'b0, 3'b001,
         o_d1, o_v1, o_m1, o_v2e, o_m2e,
         o_d2, o_v2, o_m2);
    xfer(32'h10, 32'h0, 1'b0, 1'b1, 3'b010,
         o_d1, o_v1, o_m1, o_v2e, o_m2e,
         o_d2, o_v2, o_m2);
    tests++;
    if ({o_v1, o_d1, o_v2, o_d2} !==
        {1'b1, 32'hDE551234, 1'b1, 32'hDE551234}) begin
      fails++;
      $display("FAIL sh_then_lw: v1=%b d1=%h v2=%b d2=%h want DE551234",
        o_v1, o_d1, o_v2, o_d2);
    end
  endtask

  task automatic test_misaligned();
    xfer(32'h12, 32'h0, 1'b0, 1'b1, 3'b010,
         o_d1, o_v1, o_m1, o_v2e, o_m2e,
         o_d2, o_v2, o_m2);
    tests++;
    if ({o_v1, o_m1, o_d1, o_v2e, o_m2e,
         o_v2, o_m2, o_d2} !==
        {2'b11, 32'h0, 4'b0011, 32'h0}) begin
      fails++;
      $display("FAIL lw_misaligned: v1=%b m1=%b d1=%h v2e=%b m2e=%b v2=%b m2=%b d2=%h want v=1 m=1 d=0",
        o_v1, o_m1, o_d1, o_v2e, o_m2e,
        o_v2, o_m2, o_d2);
    end
    xfer(32'h11, 32'hFFFF, 1'b1, 1'b0, 3'b001,
         o_d1, o_v1, o_m1, o_v2e, o_m2e,
         o_d2, o_v2, o_m2);
    tests++;
    if ({o_m1, o_m2e, o_v1, o_v2e, o_v2, o_m2}
        !== 6'b110000) begin
      fails++;
      $display("FAIL sh_misaligned: m1=%b m2e=%b v1=%b v2e=%b v2=%b m2=%b want 110000",
        o_m1, o_m2e, o_v1, o_v2e, o_v2, o_m2);
    end
    xfer(32'h10, 32'h0, 1'b0, 1'b1, 3'b010,
         o_d1, o_v1, o_m1, o_v2e, o_m2e,
         o_d2, o_v2, o_m2);
    tests++;
    if ({o_d1, o_d2} !==
        {32'hDE551234, 32'hDE551234}) begin
      fails++;
      $display("FAIL mis_store_no_write: d1=%h d2=%h want DE551234",
        o_d1, o_d2);
    end
    xfer(32'h10, 32'h0, 1'b0, 1'b1, 3'b011,
         o_d1, o_v1, o_m1, o_v2e, o_m2e,
         o_d2, o_v2, o_m2);
    tests++;
    if ({o_v1, o_m1, o_d1, o_v2, o_m2, o_d2} !==
        {2'b11, 32'h0, 2'b11, 32'h0}) begin
      fails++;
      $display("FAIL size_011_illegal: v1=%b m1=%b d1=%h v2=%b m2=%b d2=%h want v=1 m=1 d=0",
        o_v1, o_m1, o_d1, o_v2, o_m2, o_d2);
    end
  endtask

  task automatic test_rdw_wrap();
    xfer(32'h20, 32'hCAFEF00D, 1'b1, 1'b1, 3'b010,
         o_d1, o_v1, o_m1, o_v2e, o_m2e,
         o_d2, o_v2, o_m2);
    tests++;
    if ({o_v1, o_m1, o_d1, o_v2, o_m2, o_d2} !==
        {2'b10, 32'h0, 2'b10, 32'h0}) begin
      fails++;
      $display("FAIL rdw_old_value: v1=%b m1=%b d1=%h v2=%b m2=%b d2=%h want d=0",
        o_v1, o_m1, o_d1, o_v2, o_m2, o_d2);
    end
    xfer(32'h20, 32'h0, 1'b0, 1'b1, 3'b010,
         o_d1, o_v1, o_m1, o_v2e, o_m2e,
         o_d2, o_v2, o_m2);
    tests++;
    if ({o_d1, o_d2} !==
        {32'hCAFEF00D, 32'hCAFEF00D}) begin
      fails++;
      $display("FAIL rdw_new_value: d1=%h d2=%h want CAFEF00D",
        o_d1, o_d2);
    end
    xfer(32'h40, 32'h11223344, 1'b1, 1'b0, 3'b010,
         o_d1, o_v1, o_m1, o_v2e, o_m2e,
         o_d2, o_v2, o_m2);
    xfer(32'h00, 32'h0, 1'b0, 1'b1, 3'b010,
         o_d1, o_v1, o_m1, o_v2e, o_m2e,
         o_d2, o_v2, o_m2);
    tests++;
    if ({o_d1, o_d2} !==
        {32'h11223344, 32'h11223344}) begin
      fails++;
      $display("FAIL wrap_0x40_alias: d1=%h d2=%h want 11223344",
        o_d1, o_d2);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ad [4] = '{32'h14, 32'h00,
                            32'h10, 32'h20};
    logic [31:0] ex [4] = '{32'h0, 32'h11223344,
                            32'hDE551234, 32'hCAFEF00D};
    logic        ev;
    logic [31:0] ed;
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin
        addr = ad[k]; mr = 1'b1; sz = 3'b010;
      end else begin
        mr = 1'b0;
      end
      step();
      ev = (k < 4);
      ed = ev ? ex[k] : 32'h0;
      tests++;
      if ({b1.rd_valid,
           b1.rd_valid ? b1.read_data : 32'h0}
          !== {ev, ed}) begin
        fails++;
        $display("FAIL b2b_lat1 cyc%0d: v=%b d=%h want v=%b d=%h",
          k + 1, b1.rd_valid, b1.read_data, ev, ed);
      end
      ev = (k >= 1 && k <= 4);
      ed = ev ? ex[k-1] : 32'h0;
      tests++;
      if ({b2.rd_valid,
           b2.rd_valid ? b2.read_data : 32'h0}
          !== {ev, ed}) begin
        fails++;
        $display("FAIL b2b_lat2 cyc%0d: v=%b d=%h want v=%b d=%h",
          k + 1, b2.rd_valid, b2.read_data, ev, ed);
      end
    end
    tests++;
    if ({b1.read_data, b2.read_data} !==
        {32'hCAFEF00D, 32'hCAFEF00D}) begin
      fails++;
      $display("FAIL read_data_hold: d1=%h d2=%h want CAFEF00D",
        b1.read_data, b2.read_data);
    end
  endtask

  task automatic test_reset_midstream();
    int n;
    addr = 32'h00; mr = 1'b1; sz = 3'b010;
    step();
    rst = 1'b1; addr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({b1.rd_valid, b2.rd_valid} !== 2'b00) begin
        fails++;
        $display("FAIL midreset_suppress cyc%0d: v1=%b v2=%b want 00",
          i, b1.rd_valid, b2.rd_valid);
      end
    end
    rst = 1'b0; mr = 1'b0;
    n = 0;
    while (n < 40 && !(b1.ready && b2.ready)) begin
      step();
      n++;
    end
    tests++;
    if ({b1.ready, b2.ready} !== 2'b11) begin
      fails++;
      $display("FAIL midreset_ready_timeout: rdy=%b%b want 11",
        b1.ready, b2.ready);
    end
    xfer(32'h10, 32'h0, 1'b0, 1'b1, 3'b010,
         o_d1, o_v1, o_m1, o_v2e, o_m2e,
         o_d2, o_v2, o_m2);
    tests++;
    if ({o_v1, o_d1, o_v2, o_d2} !==
        {1'b1, 32'h0, 1'b1, 32'h0}) begin
      fails++;
      $display("FAIL reclear_lw_0x10: v1=%b d1=%h v2=%b d2=%h want d=0",
        o_v1, o_d1, o_v2, o_d2);
    end
  endtask

  initial begin
    test_reset();
    test_sized_loads();
    test_partial_stores();
    test_misaligned();
    test_rdw_wrap();
    test_back_to_back();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed",
      tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end
endmodule
